// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants for the operand fetch stage.
//   - Default datapath, register-index and immediate widths.
//   - Bit positions of the rs / rt fields inside an instruction word.
//   - Encoding of the bypass source picked by the forwarding mux.
package operand_fetch_stage_pkg;

    localparam int unsigned WORD_SIZE_DEF  = 16;
    localparam int unsigned REG_ADDR_W_DEF = 2;
    localparam int unsigned IMM_W_DEF      = 8;

    // Instruction field LSB positions: rs=[11:10], rt=[9:8].
    localparam int unsigned RS_LSB = 10;
    localparam int unsigned RT_LSB = 8;

    // Where a resolved operand comes from.
    typedef enum logic [1:0] {
        FwdRf  = 2'd0,
        FwdWb  = 2'd1,
        FwdMem = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/operand_forward_mux.sv
// One operand bypass: picks the MEM result, then the WB result, then the
// register file read data, depending on which producer targets the register.
// Ports:
//   i_src_reg   register index being read
//   i_rf_data   register file combinational read data
//   i_mem_en    MEM result valid, i_mem_reg / i_mem_data its index and value
//   i_wb_en     WB writing the file, i_wb_reg / i_wb_data its index and value
//   o_operand   resolved operand
module operand_forward_mux
    import operand_fetch_stage_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] i_src_reg,
    input  logic [WORD_SIZE-1:0]  i_rf_data,
    input  logic                  i_mem_en,
    input  logic [REG_ADDR_W-1:0] i_mem_reg,
    input  logic [WORD_SIZE-1:0]  i_mem_data,
    input  logic                  i_wb_en,
    input  logic [REG_ADDR_W-1:0] i_wb_reg,
    input  logic [WORD_SIZE-1:0]  i_wb_data,
    output logic [WORD_SIZE-1:0]  o_operand
);

    fwd_sel_e w_sel;

    // MEM is younger than WB, so it wins when both target the register.
    always_comb begin
        w_sel = FwdRf;
        if (i_mem_en && (i_mem_reg == i_src_reg)) begin
            w_sel = FwdMem;
        end else if (i_wb_en && (i_wb_reg == i_src_reg)) begin
            w_sel = FwdWb;
        end
    end

    always_comb begin
        o_operand = i_rf_data;
        unique case (w_sel)
            FwdMem:  o_operand = i_mem_data;
            FwdWb:   o_operand = i_wb_data;
            default: o_operand = i_rf_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage between decode and EX.
//   - Drives register file read addresses from the rs / rt fields.
//   - Bypasses the register file with MEM and WB results.
//   - Stalls on load-use hazards against the EX stage and counts stall cycles.
//   - Registers resolved operands into the ID/EX register with valid/ready
//     handshakes on both sides; flush squashes the register.
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   in_valid/in_ready               upstream handshake
//   in_instr, in_pc                 instruction word and its PC
//   in_uses_rs, in_uses_rt          which source registers are read
//   in_dest, in_writes              destination index and write enable
//   rf_read_reg1/2, rf_read_data1/2 register file read port
//   ex_valid, ex_is_load, ex_dest   EX stage occupant for hazard detection
//   mem_fwd_*, wb_write_*           bypass sources
//   flush                           squash (redirect)
//   out_valid/out_ready             downstream handshake
//   out_op1/2, out_imm, out_dest,
//   out_writes, out_pc              ID/EX register payload
//   stall_count                     saturating load-use stall counter
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned IMM_W      = IMM_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  in_instr,
    input  logic [WORD_SIZE-1:0]  in_pc,
    input  logic                  in_uses_rs,
    input  logic                  in_uses_rt,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_writes,

    output logic [REG_ADDR_W-1:0] rf_read_reg1,
    output logic [REG_ADDR_W-1:0] rf_read_reg2,
    input  logic [WORD_SIZE-1:0]  rf_read_data1,
    input  logic [WORD_SIZE-1:0]  rf_read_data2,

    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_dest,

    input  logic                  mem_fwd_en,
    input  logic [REG_ADDR_W-1:0] mem_fwd_reg,
    input  logic [WORD_SIZE-1:0]  mem_fwd_data,

    input  logic                  wb_write_en,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [WORD_SIZE-1:0]  wb_write_data,

    input  logic                  flush,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  out_op1,
    output logic [WORD_SIZE-1:0]  out_op2,
    output logic [WORD_SIZE-1:0]  out_imm,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic                  out_writes,
    output logic [WORD_SIZE-1:0]  out_pc,
    output logic [15:0]           stall_count
);

    // ----------------------------------------------------------------------
    // Field decode
    // ----------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [IMM_W-1:0]      w_imm;
    logic [WORD_SIZE-1:0]  w_imm_ext;
    logic                  w_unused_instr;

    assign w_rs      = in_instr[RS_LSB +: REG_ADDR_W];
    assign w_rt      = in_instr[RT_LSB +: REG_ADDR_W];
    assign w_imm     = in_instr[IMM_W-1:0];
    assign w_imm_ext = {{(WORD_SIZE-IMM_W){w_imm[IMM_W-1]}}, w_imm};

    // Opcode bits above rs are decoded upstream, not here.
    assign w_unused_instr = ^in_instr[WORD_SIZE-1:RS_LSB+REG_ADDR_W];

    assign rf_read_reg1 = w_rs;
    assign rf_read_reg2 = w_rt;

    // ----------------------------------------------------------------------
    // Bypass
    // ----------------------------------------------------------------------
    logic [WORD_SIZE-1:0] w_op1;
    logic [WORD_SIZE-1:0] w_op2;

    // WB bypass is required: the file only updates at the edge, so a
    // same-cycle read would still return the stale value.
    operand_forward_mux #(
        .WORD_SIZE  (WORD_SIZE),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_op1 (
        .i_src_reg  (w_rs),
        .i_rf_data  (rf_read_data1),
        .i_mem_en   (mem_fwd_en),
        .i_mem_reg  (mem_fwd_reg),
        .i_mem_data (mem_fwd_data),
        .i_wb_en    (wb_write_en),
        .i_wb_reg   (wb_write_reg),
        .i_wb_data  (wb_write_data),
        .o_operand  (w_op1)
    );

    operand_forward_mux #(
        .WORD_SIZE  (WORD_SIZE),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_op2 (
        .i_src_reg  (w_rt),
        .i_rf_data  (rf_read_data2),
        .i_mem_en   (mem_fwd_en),
        .i_mem_reg  (mem_fwd_reg),
        .i_mem_data (mem_fwd_data),
        .i_wb_en    (wb_write_en),
        .i_wb_reg   (wb_write_reg),
        .i_wb_data  (wb_write_data),
        .o_operand  (w_op2)
    );

    // ----------------------------------------------------------------------
    // Hazard and handshake
    // ----------------------------------------------------------------------
    logic r_out_valid;
    logic w_hz;
    logic w_slot_free;
    logic w_in_ready;
    logic w_accept;
    logic w_stall_inc;

    // A load in EX has no result yet for anything to bypass from.
    assign w_hz = in_valid & ex_valid & ex_is_load &
                  ((in_uses_rs & (ex_dest == w_rs)) | (in_uses_rt & (ex_dest == w_rt)));

    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_in_ready  = reset_n & ~flush & ~w_hz & w_slot_free;
    assign w_accept    = in_valid & w_in_ready;

    // Count only cycles actually lost to the hazard: a blocked downstream or a
    // flush would have prevented the accept anyway.
    assign w_stall_inc = reset_n & ~flush & w_hz & w_slot_free;

    assign in_ready = w_in_ready;

    // ----------------------------------------------------------------------
    // ID/EX register
    // ----------------------------------------------------------------------
    logic [WORD_SIZE-1:0]  r_op1;
    logic [WORD_SIZE-1:0]  r_op2;
    logic [WORD_SIZE-1:0]  r_imm;
    logic [REG_ADDR_W-1:0] r_dest;
    logic                  r_writes;
    logic [WORD_SIZE-1:0]  r_pc;
    logic [15:0]           r_stall_count;

    logic                  w_valid_next;
    logic                  w_load;
    logic [15:0]           w_stall_next;

    always_comb begin
        w_valid_next = r_out_valid;
        w_load       = 1'b0;
        w_stall_next = r_stall_count;

        if (flush) begin
            w_valid_next = 1'b0;
        end else if (w_accept) begin
            w_valid_next = 1'b1;
            w_load       = 1'b1;
        end else if (out_ready) begin
            w_valid_next = 1'b0;
        end

        if (w_stall_inc && (r_stall_count != 16'hFFFF)) begin
            w_stall_next = r_stall_count + 16'd1;
        end
    end

    // Payload is captured only on accept; held contents are never re-forwarded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid   <= 1'b0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_imm         <= '0;
            r_dest        <= '0;
            r_writes      <= 1'b0;
            r_pc          <= '0;
            r_stall_count <= 16'd0;
        end else begin
            r_out_valid   <= w_valid_next;
            r_stall_count <= w_stall_next;
            if (w_load) begin
                r_op1    <= w_op1;
                r_op2    <= w_op2;
                r_imm    <= w_imm_ext;
                r_dest   <= in_dest;
                r_writes <= in_writes;
                r_pc     <= in_pc;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_op1     = r_op1;
    assign out_op2     = r_op2;
    assign out_imm     = r_imm;
    assign out_dest    = r_dest;
    assign out_writes  = r_writes;
    assign out_pc      = r_pc;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_uses_rs;
    logic        in_uses_rt;
    logic [1:0]  in_dest;
    logic        in_writes;
    logic [1:0]  rf_read_reg1;
    logic [1:0]  rf_read_reg2;
    logic [15:0] rf_read_data1;
    logic [15:0] rf_read_data2;
    logic        ex_valid;
    logic        ex_is_load;
    logic [1:0]  ex_dest;
    logic        mem_fwd_en;
    logic [1:0]  mem_fwd_reg;
    logic [15:0] mem_fwd_data;
    logic        wb_write_en;
    logic [1:0]  wb_write_reg;
    logic [15:0] wb_write_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_op1;
    logic [15:0] out_op2;
    logic [15:0] out_imm;
    logic [1:0]  out_dest;
    logic        out_writes;
    logic [15:0] out_pc;
    logic [15:0] stall_count;

    int n_vec;
    int n_err;

    operand_fetch_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_uses_rs    (in_uses_rs),
        .in_uses_rt    (in_uses_rt),
        .in_dest       (in_dest),
        .in_writes     (in_writes),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .ex_valid      (ex_valid),
        .ex_is_load    (ex_is_load),
        .ex_dest       (ex_dest),
        .mem_fwd_en    (mem_fwd_en),
        .mem_fwd_reg   (mem_fwd_reg),
        .mem_fwd_data  (mem_fwd_data),
        .wb_write_en   (wb_write_en),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op1       (out_op1),
        .out_op2       (out_op2),
        .out_imm       (out_imm),
        .out_dest      (out_dest),
        .out_writes    (out_writes),
        .out_pc        (out_pc),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk_instr(input logic [1:0] rs, input logic [1:0] rt,
                                             input logic [7:0] imm);
        return {4'h0, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        reset_n       = 1'b1;
        in_valid      = 1'b0;
        in_instr      = 16'h0;
        in_pc         = 16'h0;
        in_uses_rs    = 1'b0;
        in_uses_rt    = 1'b0;
        in_dest       = 2'd0;
        in_writes     = 1'b0;
        rf_read_data1 = 16'h0;
        rf_read_data2 = 16'h0;
        ex_valid      = 1'b0;
        ex_is_load    = 1'b0;
        ex_dest       = 2'd0;
        mem_fwd_en    = 1'b0;
        mem_fwd_reg   = 2'd0;
        mem_fwd_data  = 16'h0;
        wb_write_en   = 1'b0;
        wb_write_reg  = 2'd0;
        wb_write_data = 16'h0;
        flush         = 1'b0;
        out_ready     = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        set_idle();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_instr = mk_instr(2'd1, 2'd2, 8'h55);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        step();
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_vec++;
        if (out_op1 !== 16'h0 || out_op2 !== 16'h0 || out_imm !== 16'h0 || out_pc !== 16'h0
            || out_dest !== 2'd0 || out_writes !== 1'b0) begin
            n_err++; $display("FAIL reset_payload got op1=%h op2=%h imm=%h pc=%h want 0",
                              out_op1, out_op2, out_imm, out_pc);
        end
        n_vec++;
        if (stall_count !== 16'h0) begin
            n_err++; $display("FAIL reset_stall got=%h want=0", stall_count);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready_held got=%b want=0", in_ready);
        end
        set_idle();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_rf_read();
        set_idle();
        in_valid      = 1'b1;
        in_instr      = mk_instr(2'd3, 2'd1, 8'h00);
        in_pc         = 16'h0100;
        in_dest       = 2'd3;
        in_writes     = 1'b1;
        rf_read_data1 = 16'h1234;
        rf_read_data2 = 16'h4321;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL rf_in_ready got=%b want=1", in_ready);
        end
        n_vec++;
        if (rf_read_reg1 !== 2'd3 || rf_read_reg2 !== 2'd1) begin
            n_err++; $display("FAIL rf_addr got=%0d,%0d want=3,1", rf_read_reg1, rf_read_reg2);
        end
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_op1 !== 16'h1234 || out_op2 !== 16'h4321) begin
            n_err++; $display("FAIL rf_capture got v=%b op1=%h op2=%h want 1 1234 4321",
                              out_valid, out_op1, out_op2);
        end
        n_vec++;
        if (out_pc !== 16'h0100 || out_dest !== 2'd3 || out_writes !== 1'b1) begin
            n_err++; $display("FAIL rf_meta got pc=%h dest=%0d wr=%b want 0100 3 1",
                              out_pc, out_dest, out_writes);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL rf_bubble got=%b want=0", out_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fwd_priority();
        logic [1:0]  mreg [3];
        logic [1:0]  wreg [3];
        logic [15:0] want [3];
        mreg = '{2'd2, 2'd3, 2'd3};
        wreg = '{2'd2, 2'd2, 2'd3};
        want = '{16'hAAAA, 16'hBBBB, 16'h1111};
        for (int i = 0; i < 3; i++) begin
            set_idle();
            in_valid      = 1'b1;
            in_instr      = mk_instr(2'd2, 2'd2, 8'h00);
            rf_read_data1 = 16'h1111;
            rf_read_data2 = 16'h1111;
            mem_fwd_en    = 1'b1;
            mem_fwd_reg   = mreg[i];
            mem_fwd_data  = 16'hAAAA;
            wb_write_en   = 1'b1;
            wb_write_reg  = wreg[i];
            wb_write_data = 16'hBBBB;
            step();
            in_valid = 1'b0;
            n_vec++;
            if (out_valid !== 1'b1 || out_op1 !== want[i] || out_op2 !== want[i]) begin
                n_err++; $display("FAIL fwd_prio[%0d] got v=%b op1=%h op2=%h want %h",
                                  i, out_valid, out_op1, out_op2, want[i]);
            end
            step();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_use();
        set_idle();
        in_valid      = 1'b1;
        in_instr      = mk_instr(2'd0, 2'd1, 8'h00);
        in_pc         = 16'h0040;
        in_uses_rt    = 1'b1;
        rf_read_data1 = 16'h5555;
        rf_read_data2 = 16'h6666;
        ex_valid      = 1'b1;
        ex_is_load    = 1'b1;
        ex_dest       = 2'd1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL lu_in_ready got=%b want=0", in_ready);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0 || stall_count !== 16'd1) begin
            n_err++; $display("FAIL lu_bubble got v=%b stall=%0d want 0 1", out_valid, stall_count);
        end
        ex_valid = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL lu_release got=%b want=1", in_ready);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_op2 !== 16'h6666 || stall_count !== 16'd1) begin
            n_err++; $display("FAIL lu_accept got v=%b op2=%h stall=%0d want 1 6666 1",
                              out_valid, out_op2, stall_count);
        end
    endtask

    // ------------------------------------------------------------------
    // Relies on test_load_use leaving the register full.
    task automatic test_hold_flush();
        in_valid      = 1'b1;
        in_instr      = mk_instr(2'd1, 2'd1, 8'h33);
        in_pc         = 16'h0080;
        rf_read_data1 = 16'h0F0F;
        rf_read_data2 = 16'hF0F0;
        mem_fwd_en    = 1'b1;
        mem_fwd_reg   = 2'd1;
        mem_fwd_data  = 16'hDEAD;
        out_ready     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL hold_in_ready[%0d] got=%b want=0", i, in_ready);
            end
            step();
            n_vec++;
            if (out_valid !== 1'b1 || out_op1 !== 16'h5555 || out_op2 !== 16'h6666
                || out_pc !== 16'h0040) begin
                n_err++; $display("FAIL hold_payload[%0d] got v=%b op1=%h op2=%h pc=%h want 1 5555 6666 0040",
                                  i, out_valid, out_op1, out_op2, out_pc);
            end
        end
        flush      = 1'b1;
        in_uses_rt = 1'b1;
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_dest    = 2'd1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_in_ready got=%b want=0", in_ready);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0 || stall_count !== 16'd1) begin
            n_err++; $display("FAIL flush got v=%b stall=%0d want 0 1", out_valid, stall_count);
        end
        set_idle();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_imm_back_to_back();
        set_idle();
        in_valid = 1'b1;
        in_instr = mk_instr(2'd0, 2'd0, 8'h80);
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_imm !== 16'hFF80) begin
            n_err++; $display("FAIL imm_neg got v=%b imm=%h want 1 FF80", out_valid, out_imm);
        end
        in_instr = mk_instr(2'd0, 2'd0, 8'h7F);
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_in_ready got=%b want=1", in_ready);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_imm !== 16'h007F) begin
            n_err++; $display("FAIL imm_pos got v=%b imm=%h want 1 007F", out_valid, out_imm);
        end
        set_idle();
        step();
    endtask

    // ------------------------------------------------------------------
    // Reference model: ID/EX contents as plain variables.
    logic        m_valid;
    logic [15:0] m_op1, m_op2, m_imm, m_pc, m_stall;
    logic [1:0]  m_dest;
    logic        m_writes;

    function automatic logic [15:0] ref_operand(input logic [1:0] idx, input logic [15:0] rf);
        if (mem_fwd_en && mem_fwd_reg == idx) return mem_fwd_data;
        if (wb_write_en && wb_write_reg == idx) return wb_write_data;
        return rf;
    endfunction

    task automatic test_random();
        logic [1:0]  rs, rt;
        logic        hz, rdy;
        logic [15:0] tmp;
        set_idle();
        reset_n = 1'b0;
        step();
        m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_imm = '0; m_pc = '0;
        m_dest = '0; m_writes = 1'b0; m_stall = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset_n       = ($urandom_range(0, 49) != 0);
            flush         = ($urandom_range(0, 9) == 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 9) < 7);
            tmp           = 16'($urandom);
            in_instr      = tmp;
            in_pc         = 16'($urandom);
            in_uses_rs    = 1'($urandom);
            in_uses_rt    = 1'($urandom);
            in_dest       = 2'($urandom);
            in_writes     = 1'($urandom);
            rf_read_data1 = 16'($urandom);
            rf_read_data2 = 16'($urandom);
            ex_valid      = 1'($urandom);
            ex_is_load    = 1'($urandom);
            ex_dest       = 2'($urandom);
            mem_fwd_en    = 1'($urandom);
            mem_fwd_reg   = 2'($urandom);
            mem_fwd_data  = 16'($urandom);
            wb_write_en   = 1'($urandom);
            wb_write_reg  = 2'($urandom);
            wb_write_data = 16'($urandom);
            rs = tmp[11:10];
            rt = tmp[9:8];
            hz  = in_valid && ex_valid && ex_is_load &&
                  ((in_uses_rs && ex_dest == rs) || (in_uses_rt && ex_dest == rt));
            rdy = reset_n && !flush && !hz && (!m_valid || out_ready);
            #1;
            n_vec++;
            if (in_ready !== rdy) begin
                n_err++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, rdy);
            end
            n_vec++;
            if (rf_read_reg1 !== rs || rf_read_reg2 !== rt) begin
                n_err++; $display("FAIL rnd_rf_addr cyc=%0d got=%0d,%0d want=%0d,%0d",
                                  cyc, rf_read_reg1, rf_read_reg2, rs, rt);
            end
            if (!reset_n) begin
                m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_imm = '0; m_pc = '0;
                m_dest = '0; m_writes = 1'b0; m_stall = '0;
            end else begin
                if (hz && !flush && (!m_valid || out_ready) && m_stall != 16'hFFFF)
                    m_stall = m_stall + 16'd1;
                if (flush) begin
                    m_valid = 1'b0;
                end else if (in_valid && rdy) begin
                    m_valid  = 1'b1;
                    m_op1    = ref_operand(rs, rf_read_data1);
                    m_op2    = ref_operand(rt, rf_read_data2);
                    m_imm    = {{8{tmp[7]}}, tmp[7:0]};
                    m_pc     = in_pc;
                    m_dest   = in_dest;
                    m_writes = in_writes;
                end else if (out_ready) begin
                    m_valid = 1'b0;
                end
            end
            step();
            n_vec++;
            if (out_valid !== m_valid || stall_count !== m_stall) begin
                n_err++; $display("FAIL rnd_state cyc=%0d got v=%b stall=%0d want v=%b stall=%0d",
                                  cyc, out_valid, stall_count, m_valid, m_stall);
            end
            if (m_valid) begin
                n_vec++;
                if (out_op1 !== m_op1 || out_op2 !== m_op2 || out_imm !== m_imm
                    || out_pc !== m_pc || out_dest !== m_dest || out_writes !== m_writes) begin
                    n_err++; $display("FAIL rnd_payload cyc=%0d got %h %h %h %h %0d %b want %h %h %h %h %0d %b",
                                      cyc, out_op1, out_op2, out_imm, out_pc, out_dest, out_writes,
                                      m_op1, m_op2, m_imm, m_pc, m_dest, m_writes);
                end
            end
        end
        set_idle();
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        set_idle();
        test_reset();
        test_rf_read();
        test_fwd_priority();
        test_load_use();
        test_hold_flush();
        test_imm_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
